dac_spi_frame_scheduler: RTL and testbench
==========================================

Name: dac_spi_frame_scheduler

Overview:
- Sequences the shared dual-channel 12-bit SPI DAC (MCP4922-style) between NCO channels A and B.
- Generates the sample-rate tick, latches both channel samples and serialises one 16-bit word per enabled channel over a single SPI bus.
- Pulses ldac_n low so both outputs update together.
- ldac_n also drives the NCO accumulators' clk_LDAC input, whose falling edge advances the phase.

Parameters:
SAMPLE_DIV, 1000, clk cycles per sample period (50 MHz / 1000 = 50 kHz); must be >= 2
SCLK_DIV, 2, clk cycles per SCLK half-period; must be >= 1
LDAC_LEN, 2, clk cycles ldac_n is held low; must be >= 1
BUF_BIT, 0, value placed in word bit 14 (VREF buffer)
GA_N_BIT, 1, value placed in word bit 13 (1 = 1x gain)

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
enable  in  1  1 = sample tick counter runs
ch_en_a  in  1  include channel A word in frame
ch_en_b  in  1  include channel B word in frame
sample_a  in  12  channel A DAC code (NCO/BRAM output)
sample_b  in  12  channel B DAC code
clr_overrun  in  1  one-cycle clear of overrun flag
cs_n  out  1  SPI chip select, active low
sclk  out  1  SPI clock, idle low
mosi  out  1  SPI data, MSB first
ldac_n  out  1  DAC latch strobe, active low (also NCO clk_LDAC)
busy  out  1  1 while state != IDLE
frame_done  out  1  one-cycle pulse on the last LDAC cycle
overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset (async, immediate): cs_n=1, sclk=0, mosi=0, ldac_n=1, busy=0, frame_done=0, overrun=0, tick counter=0, state=IDLE. Reset mid-frame aborts it with no partial LDAC.
- Tick counter: enable=0 holds counter at 0. Otherwise it counts 0..SAMPLE_DIV-1 and wraps; tick=1 on the cycle count==SAMPLE_DIV-1. First tick arrives SAMPLE_DIV cycles after enable rises.
- Word format: bit15 = channel (0=A, 1=B), bit14 = BUF_BIT, bit13 = GA_N_BIT, bit12 = 1 (SHDN_n), bits11:0 = sample.
- States: IDLE, LOAD, CS_SETUP, SHIFT, GAP, LDAC.
- IDLE: on tick, if ch_en_a or ch_en_b -> LOAD. If both are 0, the tick is ignored: no frame, no LDAC, no overrun.
- LOAD (1 cycle): latch sample_a, sample_b, ch_en_a, ch_en_b into shadow registers. Input changes after this cycle do not affect the frame. Next channel = A if enabled, else B. -> CS_SETUP.
- CS_SETUP (SCLK_DIV cycles): cs_n=0, sclk=0, mosi=word[15]. -> SHIFT.
- SHIFT (16 bits, 2*SCLK_DIV cycles each):
  - sclk=1 for SCLK_DIV cycles, then sclk=0 for SCLK_DIV cycles.
  - mosi changes only on the sclk falling transition, to the next bit. After the 16th bit it is 0.
  - The final low half-period is the CS hold time, with cs_n still 0.
  - -> GAP.
- GAP (SCLK_DIV cycles): cs_n=1, sclk=0. After GAP: if channel was A and B is enabled -> CS_SETUP for B; else -> LDAC.
- LDAC (LDAC_LEN cycles): ldac_n=0. frame_done=1 on the last cycle. -> IDLE.
- Frame length = 1 + words*(34*SCLK_DIV) + LDAC_LEN cycles. Defaults, two words: 139 cycles.
- Overrun: a tick while state != IDLE sets overrun and is dropped. The current frame is unaffected. If set and clr_overrun coincide, set wins.
- enable falling mid-frame: the current frame completes normally; no further ticks.
- ch_en_* changes mid-frame: take effect at the next LOAD only.
- Exactly one ldac_n low pulse per completed frame, never during cs_n=0.

Test Plan:
1. Reset, enable=1, both ch_en=1, sample_a=0xABC, sample_b=0x123 -> first cs_n fall at cycle 1001 after enable. Words captured on sclk rising edges are 0x3ABC then 0xB123. ldac_n low 2 cycles at frame cycles 137-138. frame_done=1 once.
2. ch_en_a=0, ch_en_b=1, sample_b=0xFFF -> single word 0xBFFF. Frame length 71 cycles. One LDAC pulse per tick.
3. Both ch_en=0 for 3 ticks -> cs_n, ldac_n stay 1. busy=0, overrun=0.
4. SAMPLE_DIV=100, SCLK_DIV=2, two channels (139-cycle frame) -> overrun=1 after second tick. Frames still complete in order. clr_overrun pulse on a tick-while-busy cycle leaves overrun=1.
5. Change sample_a from 0x001 to 0x800 one cycle after LOAD -> transmitted A word 0x3001. Next frame transmits 0x3800.
6. Assert resetn=0 mid-SHIFT of word A -> same cycle cs_n=1, sclk=0, mosi=0, ldac_n=1, busy=0. After release, the next frame starts only after a full SAMPLE_DIV count.

Source files
------------

// File: rtl/dac_spi_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dac_spi_frame_scheduler
//  Description : Sample-rate frame sequencer for a shared dual-channel 12-bit
//                SPI DAC. Each enabled sample tick latches both channel codes,
//                shifts one 16-bit word per enabled channel (A first), then
//                pulses ldac_n low so both DAC outputs update together.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_spi_frame_scheduler #(
    parameter int   SAMPLE_DIV = 1000,
    parameter int   SCLK_DIV   = 2,
    parameter int   LDAC_LEN   = 2,
    parameter logic BUF_BIT    = 1'b0,
    parameter logic GA_N_BIT   = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        ch_en_a,
    input  logic        ch_en_b,
    input  logic [11:0] sample_a,
    input  logic [11:0] sample_b,
    input  logic        clr_overrun,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    output logic        ldac_n,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int DW = $clog2(SCLK_DIV + LDAC_LEN + 1);

    localparam logic [TW-1:0] c_tick_last = TW'(SAMPLE_DIV - 1);
    localparam logic [DW-1:0] c_sclk_last = DW'(SCLK_DIV - 1);
    localparam logic [DW-1:0] c_ldac_last = DW'(LDAC_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_CS_SETUP = 3'd2,
        S_SHIFT    = 3'd3,
        S_GAP      = 3'd4,
        S_LDAC     = 3'd5
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tcnt;
    logic [DW-1:0]   r_div;       // cycles spent in the current phase
    logic [3:0]      r_bit;       // index of the bit being shifted (0 = MSB)
    logic            r_high;      // 1 while in the sclk-high half of a bit
    logic [14:0]     r_shift;     // remaining bits of the word; MSB goes out directly
    logic            r_chan;      // channel of the word in flight (0 = A)
    logic            r_en_b;      // shadow of ch_en_b taken at LOAD
    logic [11:0]     r_sample_b;  // shadow of sample_b taken at LOAD

    logic            w_tick;
    logic [15:0]     w_word_a;
    logic [15:0]     w_word_b_live;
    logic [15:0]     w_word_b_shadow;

    // DAC command word: channel select, buffer, gain, active (not shutdown), code
    function automatic logic [15:0] make_word(input logic ch, input logic [11:0] code);
        return {ch, BUF_BIT, GA_N_BIT, 1'b1, code};
    endfunction

    assign w_tick          = enable && (r_tcnt == c_tick_last);
    assign w_word_a        = make_word(1'b0, sample_a);
    assign w_word_b_live   = make_word(1'b1, sample_b);
    assign w_word_b_shadow = make_word(1'b1, r_sample_b);

    // Sample-period counter; held at zero while disabled so the first tick
    // always lands a full period after enable rises.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tcnt <= '0;
        end else if (!enable || (r_tcnt == c_tick_last)) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // Frame sequencer; every SPI/LDAC output is registered alongside the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            cs_n       <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            ldac_n     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            r_div      <= '0;
            r_bit      <= '0;
            r_high     <= 1'b0;
            r_shift    <= '0;
            r_chan     <= 1'b0;
            r_en_b     <= 1'b0;
            r_sample_b <= '0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick && (ch_en_a || ch_en_b)) begin
                        busy    <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_en_b     <= ch_en_b;
                    r_sample_b <= sample_b;
                    r_div      <= '0;
                    if (ch_en_a) begin
                        r_chan  <= 1'b0;
                        r_shift <= w_word_a[14:0];
                        mosi    <= w_word_a[15];
                        cs_n    <= 1'b0;
                        r_state <= S_CS_SETUP;
                    end else if (ch_en_b) begin
                        r_chan  <= 1'b1;
                        r_shift <= w_word_b_live[14:0];
                        mosi    <= w_word_b_live[15];
                        cs_n    <= 1'b0;
                        r_state <= S_CS_SETUP;
                    end else begin
                        // Both channels dropped before the latch: abandon quietly.
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                S_CS_SETUP: begin
                    if (r_div == c_sclk_last) begin
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_high  <= 1'b1;
                        sclk    <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (r_div != c_sclk_last) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (r_high) begin
                            // Falling edge: present the next bit (zero after the LSB).
                            r_high  <= 1'b0;
                            sclk    <= 1'b0;
                            mosi    <= r_shift[14];
                            r_shift <= {r_shift[13:0], 1'b0};
                        end else if (r_bit == 4'd15) begin
                            // Low half of the last bit doubled as CS hold time.
                            cs_n    <= 1'b1;
                            r_state <= S_GAP;
                        end else begin
                            r_bit  <= r_bit + 1'b1;
                            r_high <= 1'b1;
                            sclk   <= 1'b1;
                        end
                    end
                end

                S_GAP: begin
                    if (r_div != c_sclk_last) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!r_chan && r_en_b) begin
                            r_chan  <= 1'b1;
                            r_shift <= w_word_b_shadow[14:0];
                            mosi    <= w_word_b_shadow[15];
                            cs_n    <= 1'b0;
                            r_state <= S_CS_SETUP;
                        end else begin
                            ldac_n     <= 1'b0;
                            frame_done <= (LDAC_LEN == 1);
                            r_state    <= S_LDAC;
                        end
                    end
                end

                S_LDAC: begin
                    if (r_div == c_ldac_last) begin
                        r_div   <= '0;
                        ldac_n  <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_div      <= r_div + 1'b1;
                        frame_done <= ((r_div + 1'b1) == c_ldac_last);
                    end
                end

                default: begin
                    cs_n    <= 1'b1;
                    sclk    <= 1'b0;
                    mosi    <= 1'b0;
                    ldac_n  <= 1'b1;
                    busy    <= 1'b0;
                    r_div   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: a tick landing on any non-idle cycle is dropped and
    // flagged; a simultaneous clear loses to the new event.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun <= 1'b0;
        end else if (w_tick && (r_state != S_IDLE)) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dac_spi_frame_scheduler
//  Description : Self-checking bench for dac_spi_frame_scheduler. A frame-level
//                model predicts every output on every cycle; directed scenarios
//                pin tick timing, captured SPI words, LDAC placement, overrun,
//                input shadowing and mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_spi_frame_scheduler;

    localparam int SD   = 100;
    localparam int S    = 2;
    localparam int L    = 2;
    localparam int WCYC = 34 * S;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        ch_en_a = 1'b0;
    logic        ch_en_b = 1'b0;
    logic [11:0] sample_a = '0;
    logic [11:0] sample_b = '0;
    logic        clr_overrun = 1'b0;
    logic        cs_n, sclk, mosi, ldac_n, busy, frame_done, overrun;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    dac_spi_frame_scheduler #(
        .SAMPLE_DIV (SD),
        .SCLK_DIV   (S),
        .LDAC_LEN   (L),
        .BUF_BIT    (1'b0),
        .GA_N_BIT   (1'b1)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .ch_en_a     (ch_en_a),
        .ch_en_b     (ch_en_b),
        .sample_a    (sample_a),
        .sample_b    (sample_b),
        .clr_overrun (clr_overrun),
        .cs_n        (cs_n),
        .sclk        (sclk),
        .mosi        (mosi),
        .ldac_n      (ldac_n),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // ---------------- frame-level reference model ----------------
    int          m_tcnt = 0;
    bit          m_active = 0;
    bit          m_tick;
    int          m_fk = 0, m_nw = 0, m_flen = 0;
    logic        m_ovr = 1'b0;
    logic [15:0] m_words [2];
    int          p, q, r, b;
    logic [15:0] wd;
    logic        e_cs, e_sclk, e_mosi, e_ldac, e_busy, e_fd;

    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_tcnt = 0; m_active = 0; m_fk = 0; m_ovr = 1'b0;
            end else begin
                m_tick = enable && (m_tcnt == SD - 1);
                if (m_tick && m_active) m_ovr = 1'b1;
                else if (clr_overrun)   m_ovr = 1'b0;
                if (m_active) begin
                    if (m_fk == 0) begin
                        m_nw = 0;
                        if (ch_en_a) begin m_words[0] = {4'b0011, sample_a}; m_nw = 1; end
                        if (ch_en_b) begin m_words[m_nw] = {4'b1011, sample_b}; m_nw++; end
                        m_flen = 1 + m_nw * WCYC + L;
                    end
                    m_fk++;
                    if (m_fk == m_flen) m_active = 0;
                end else if (m_tick && (ch_en_a || ch_en_b)) begin
                    m_active = 1; m_fk = 0;
                end
                m_tcnt = enable ? (m_tcnt + 1) % SD : 0;
            end
            e_cs = 1; e_sclk = 0; e_mosi = 0; e_ldac = 1; e_busy = 0; e_fd = 0;
            if (m_active) begin
                e_busy = 1;
                if (m_fk >= 1) begin
                    p = m_fk - 1;
                    if (p < m_nw * WCYC) begin
                        wd = m_words[p / WCYC];
                        q  = p % WCYC;
                        if (q < S) begin
                            e_cs = 0; e_mosi = wd[15];
                        end else if (q < S + 32 * S) begin
                            r = q - S; b = r / (2 * S); e_cs = 0;
                            if ((r % (2 * S)) < S) begin e_sclk = 1; e_mosi = wd[15 - b]; end
                            else e_mosi = (b == 15) ? 1'b0 : wd[14 - b];
                        end
                    end else begin
                        e_ldac = 0;
                        e_fd   = (m_fk == m_flen - 1);
                    end
                end
            end
            check($sformatf("outputs@cycle%0d {cs,sclk,mosi,ldac,busy,fd,ovr}", cyc),
                  {cs_n, sclk, mosi, ldac_n, busy, frame_done, overrun},
                  {e_cs, e_sclk, e_mosi, e_ldac, e_busy, e_fd, m_ovr});
        end
    end

    // ---------------- SPI word capture on sclk rising edges ----------------
    logic [15:0] capq [$];
    logic [15:0] cap = '0;
    int          nb = 0;

    initial begin
        forever begin
            @(posedge sclk or posedge cs_n);
            if (cs_n === 1'b1) begin
                if (nb == 16) capq.push_back(cap);
                nb = 0;
            end else begin
                cap = {cap[14:0], mosi};
                nb++;
            end
        end
    end

    // ---------------- per-frame shape monitor ----------------
    int run_len = 0, run_ldac = 0, run_fd = 0, ldac_at = -1;
    int last_len = 0, last_ldac_at = -1, last_ldac_len = 0, last_fd = 0;
    int frames_done = 0, ldac_pulses = 0, cs_low_cycles = 0, busy_cycles = 0;
    logic prev_ldac = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (ldac_n === 1'b0 && prev_ldac === 1'b1) ldac_pulses++;
            prev_ldac = ldac_n;
            if (cs_n === 1'b0) cs_low_cycles++;
            if (busy === 1'b1) begin
                busy_cycles++;
                if (ldac_n === 1'b0 && run_ldac == 0) ldac_at = run_len;
                if (ldac_n === 1'b0) run_ldac++;
                if (frame_done === 1'b1) run_fd++;
                run_len++;
            end else if (run_len > 0) begin
                last_len = run_len; last_ldac_at = ldac_at;
                last_ldac_len = run_ldac; last_fd = run_fd;
                frames_done++;
                run_len = 0; run_ldac = 0; run_fd = 0; ldac_at = -1;
            end
        end
    end

    task automatic wait_frames(input int n, input int budget, input string what);
        int target;
        int k;
        target = frames_done + n;
        k = 0;
        while (frames_done < target && k < budget) begin step(1); k++; end
        check({what, " completed in budget"}, (frames_done >= target), 1);
    endtask

    function automatic logic [15:0] capw(input int i);
        return (capq.size() > i) ? capq[i] : 16'hxxxx;
    endfunction

    // ---------------- directed + random stimulus ----------------
    int t0, k, p0, c0, b0;

    initial begin
        resetn = 1'b0;
        step(3);
        check("reset outputs", {cs_n, sclk, mosi, ldac_n, busy, frame_done, overrun}, 7'b1001000);
        resetn = 1'b1;
        step(2);

        // Two-channel frame: tick timing, words, LDAC placement
        sample_a = 12'hABC; sample_b = 12'h123; ch_en_a = 1; ch_en_b = 1;
        capq.delete();
        enable = 1; t0 = cyc;
        k = 0;
        while (cs_n && k < 300) begin step(1); k++; end
        check("first cs_n fall after enable", cyc - t0, SD + 1);
        wait_frames(1, 300, "frame1");
        check("frame1 word count", capq.size(), 2);
        check("frame1 word A", capw(0), 16'h3ABC);
        check("frame1 word B", capw(1), 16'hB123);
        check("frame1 length", last_len, 139);
        check("frame1 ldac start", last_ldac_at, 137);
        check("frame1 ldac length", last_ldac_len, 2);
        check("frame1 frame_done count", last_fd, 1);
        check("overrun after second tick", overrun, 1);

        // Clear while idle of ticks, then clear colliding with a busy tick
        while (cyc < t0 + 349) step(1);
        clr_overrun = 1; step(1); clr_overrun = 0;
        check("overrun cleared", overrun, 0);
        while (cyc < t0 + 399) step(1);
        clr_overrun = 1; step(1); clr_overrun = 0;
        check("set wins over clear", overrun, 1);
        wait_frames(1, 300, "frame2");

        // Shadowing: sample_a changes one cycle after LOAD
        sample_a = 12'h001;
        capq.delete();
        k = 0;
        while (!busy && k < 300) begin step(1); k++; end
        step(1);
        sample_a = 12'h800;
        wait_frames(1, 300, "shadow frame");
        check("word A latched at LOAD", capw(0), 16'h3001);
        capq.delete();
        wait_frames(1, 400, "next frame");
        check("word A next frame", capw(0), 16'h3800);

        // Single channel B
        ch_en_a = 0; sample_b = 12'hFFF;
        capq.delete();
        wait_frames(1, 400, "single-B frame");
        check("single-B word count", capq.size(), 1);
        check("single-B word", capw(0), 16'hBFFF);
        check("single-B length", last_len, 71);
        p0 = ldac_pulses;
        step(3 * SD);
        check("one ldac pulse per tick", ldac_pulses - p0, 3);

        // Both channels disabled: ticks ignored
        ch_en_b = 0;
        k = 0;
        while (busy && k < 200) begin step(1); k++; end
        clr_overrun = 1; step(1); clr_overrun = 0;
        p0 = ldac_pulses; c0 = cs_low_cycles; b0 = busy_cycles;
        step(3 * SD + 20);
        check("disabled: no cs_n activity", cs_low_cycles - c0, 0);
        check("disabled: no ldac pulse", ldac_pulses - p0, 0);
        check("disabled: never busy", busy_cycles - b0, 0);
        check("disabled: no overrun", overrun, 0);

        // Randomised traffic under the per-cycle model
        ch_en_a = 1; ch_en_b = 1;
        for (int i = 0; i < 4000; i++) begin
            sample_a = 12'($urandom);
            sample_b = 12'($urandom);
            if ($urandom_range(0, 49) == 0) {ch_en_a, ch_en_b} = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 399) == 0) enable = ~enable;
            clr_overrun = ($urandom_range(0, 29) == 0);
            step(1);
        end
        clr_overrun = 0;

        // Reset in the middle of word A's shift
        enable = 1; ch_en_a = 1; ch_en_b = 1;
        k = 0;
        while (busy && k < 400) begin step(1); k++; end
        k = 0;
        while (!(busy && !cs_n && sclk) && k < 400) begin step(1); k++; end
        check("reached word A shift", (busy && !cs_n && sclk), 1);
        step(5);
        p0 = ldac_pulses;
        resetn = 0;
        #1;
        check("async reset outputs", {cs_n, sclk, mosi, ldac_n, busy, frame_done, overrun}, 7'b1001000);
        step(2);
        resetn = 1; t0 = cyc;
        k = 0;
        while (cs_n && k < 300) begin step(1); k++; end
        check("restart after full period", cyc - t0, SD + 1);
        check("no partial ldac", ldac_pulses - p0, 0);
        capq.delete();
        wait_frames(1, 300, "post-reset frame");
        check("post-reset word count", capq.size(), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
